uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  Sequencing FSM for the UART receive datapath.
//  - Synchronises the serial line, detects the start bit and oversamples each bit.
//  - Drives sample_out_reg plus the SIPO/parity/stop/check enable strobes to the datapath.
//  - Also produces busy and error pulses for the RX top level.
// PARAMETERS
//  DATA_WIDTH  4  data bits per frame; must match the datapath
//  PRESCALE    8  clk cycles per bit; even, >=8
//  PAR_EN      1  1: frame carries a parity bit; 0: no parity bit
// PORTS
//  clk             in   1           system clock; all logic on the rising edge
//  rst             in   1           asynchronous reset, active low
//  rx_in           in   1           raw serial line; idle level 1
//  SIPO_DONE       in   1           datapath: all data bits shifted in
//  sample_out_reg  out  1           registered bit decision to the datapath
//  SIPO_EN         out  1           1-cycle strobe per data bit
//  PAR_CHECK_EN    out  1           1-cycle strobe on the parity bit
//  STOP_CHECK_EN   out  1           1-cycle strobe on the stop bit
//  RX_CHECK_EN     out  1           1-cycle strobe, frame result capture
//  busy            out  1           high while a frame is in progress
//  start_glitch    out  1           1-cycle pulse: false start rejected
//  seq_err         out  1           1-cycle pulse: SIPO_DONE mismatch
// BEHAVIOUR
//  Reset (rst=0, async):
//   - FSM goes to IDLE; counters clear; ARMED clears.
//   - Both synchroniser flops, and sample_out_reg, go to 1.
//   - All other outputs go to 0.
//   - Reset mid-frame aborts the frame immediately; no strobes follow.
//  Synchroniser: rx_in passes through 2 flops to give rx_s (2-cycle latency). All decisions use rx_s.
//  Counters:
//   - edge_cnt runs 0..PRESCALE-1 and wraps to 0 at the end of each bit.
//   - bit_cnt runs 0..DATA_WIDTH-1 in DATA.
//  Sampling, with M = PRESCALE/2:
//   - sample_out_reg loads on the edge where edge_cnt==M+1.
//   - The state's strobe is high during edge_cnt==M+2, i.e. 1 cycle after the load.
//   - sample_out_reg holds its value until the next load.
//  FSM states:
//   - IDLE:
//     - ARMED sets when rx_s==1.
//     - ARMED && rx_s==0 -> START, with edge_cnt=0.
//     - Without ARMED, a line stuck low never starts a frame.
//   - START:
//     - At the strobe cycle, sample_out_reg==1 -> start_glitch pulse, then IDLE.
//     - Otherwise, at edge_cnt==PRESCALE-1 -> DATA with bit_cnt=0.
//   - DATA:
//     - SIPO_EN at each strobe.
//     - At edge_cnt==PRESCALE-1: if bit_cnt==DATA_WIDTH-1, go to PARITY (PAR_EN=1) or STOP (PAR_EN=0); else bit_cnt++.
//     - If SIPO_DONE==0 on that final edge, seq_err pulses the next cycle (frame continues).
//   - PARITY: PAR_CHECK_EN at the strobe; at edge_cnt==PRESCALE-1 -> STOP.
//   - STOP:
//     - STOP_CHECK_EN at the strobe.
//     - The next cycle -> CHECK; the rest of the stop bit is not waited for.
//   - CHECK: RX_CHECK_EN high for exactly 1 cycle; ARMED clears; -> IDLE.
//  busy = (state != IDLE).
//  Strobes are mutually exclusive; at most one strobe per bit period.
//  Back-to-back frames:
//   - A new start is accepted as soon as IDLE sees rx_s==1 then 0.
//   - This gives a minimum inter-frame gap of 1 cycle after ARMED.
//  A stop bit sampled as 0 still gives STOP_CHECK_EN/RX_CHECK_EN; the datapath flags stop_error.
// CONFIGURATION
//  RX_MAJ_VOTE_EN defined:
//   - rx_s is captured at edge_cnt==M-1, M and M+1.
//   - sample_out_reg = 2-of-3 majority, loaded at M+1.
//  RX_MAJ_VOTE_EN undefined:
//   - sample_out_reg = rx_s, loaded at edge_cnt==M+1 (single sample).
//  Strobe timing is identical either way.
// TESTING  (DATA_WIDTH=4, PRESCALE=8, PAR_EN=1)
//  1. Frame 0x5 LSB-first, odd parity (line 0,1,0,1,0,1,1):
//     - 4 SIPO_EN pulses, 8 cycles apart, with sample_out_reg=1,0,1,0.
//     - Then PAR_CHECK_EN with sample_out_reg=1, STOP_CHECK_EN with 1, and one RX_CHECK_EN.
//     - busy then falls.
//  2. rx_in low for 3 cycles only:
//     - start_glitch pulses once; no SIPO_EN; FSM returns to IDLE.
//  3. Two frames 0xA,0x3 separated by a 1-bit idle:
//     - 8 SIPO_EN and 2 RX_CHECK_EN; no seq_err.
//  4. rst=0 during data bit 2:
//     - All outputs 0 and sample_out_reg=1 in the same cycle.
//     - Then a clean frame decodes correctly.
//  5. Stop bit driven 0 and line held low:
//     - RX_CHECK_EN pulses once; no new START until rx_in returns to 1.
//  6. With RX_MAJ_VOTE_EN: a 1-cycle 0 glitch at edge M inside a 1 bit still gives sample_out_reg=1.
//     Without the macro, the same glitch at M+1 gives 0.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: syncs rx_in, validates the start bit, oversamples each bit and strobes the datapath.
// Optional RX_MAJ_VOTE_EN: 2-of-3 majority over edge_cnt M-1..M+1 instead of a single sample at M+1.
module uart_rx_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int PRESCALE   = 8,
  parameter int PAR_EN     = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_in,
  input  logic SIPO_DONE,
  output logic sample_out_reg,
  output logic SIPO_EN,
  output logic PAR_CHECK_EN,
  output logic STOP_CHECK_EN,
  output logic RX_CHECK_EN,
  output logic busy,
  output logic start_glitch,
  output logic seq_err
);

  localparam int EW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam int M  = PRESCALE / 2;

  localparam logic [EW-1:0] E_ONE  = EW'(1);
  localparam logic [EW-1:0] E_LAST = EW'(PRESCALE - 1);
  localparam logic [EW-1:0] E_LOAD = EW'(M + 1);
  localparam logic [EW-1:0] E_STRB = EW'(M + 2);
  localparam logic [BW-1:0] B_ONE  = BW'(1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    CHECK  = 3'd5
  } state_e;

  state_e          state_q, state_d;
  logic [1:0]      sync_q, sync_d;
  logic [EW-1:0]   edge_cnt_q, edge_cnt_d;
  logic [BW-1:0]   bit_cnt_q, bit_cnt_d;
  logic            armed_q, armed_d;
  logic            sample_q, sample_d;
  logic            seq_err_q, seq_err_d;
  logic            rx_s;
  logic            at_strobe;
  logic            at_last;
  logic            bit_value;

  assign rx_s      = sync_q[1];
  assign at_strobe = (edge_cnt_q == E_STRB);
  assign at_last   = (edge_cnt_q == E_LAST);

`ifdef RX_MAJ_VOTE_EN
  localparam logic [EW-1:0] E_VOTE0 = EW'(M - 1);
  localparam logic [EW-1:0] E_VOTE1 = EW'(M);

  logic [1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (edge_cnt_q == E_VOTE0) vote_d[0] = rx_s;
    if (edge_cnt_q == E_VOTE1) vote_d[1] = rx_s;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vote_q <= 2'b11;
    else      vote_q <= vote_d;
  end

  // Third vote is the live rx_s at the load edge.
  assign bit_value = (vote_q[0] & vote_q[1]) | (vote_q[0] & rx_s) | (vote_q[1] & rx_s);
`else
  assign bit_value = rx_s;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      sync_q     <= 2'b11;
      edge_cnt_q <= '0;
      bit_cnt_q  <= '0;
      armed_q    <= 1'b0;
      sample_q   <= 1'b1;
      seq_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      edge_cnt_q <= edge_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      armed_q    <= armed_d;
      sample_q   <= sample_d;
      seq_err_q  <= seq_err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (armed_q && !rx_s) state_d = START;
      START: begin
        if (at_strobe && sample_q) state_d = IDLE;
        else if (at_last)          state_d = DATA;
      end
      DATA:   if (at_last && bit_cnt_q == B_LAST) state_d = (PAR_EN != 0) ? PARITY : STOP;
      PARITY: if (at_last) state_d = STOP;
      // The tail of the stop bit is not waited for, so IDLE can re-arm early.
      STOP:   if (at_strobe) state_d = CHECK;
      CHECK:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    sync_d = {sync_q[0], rx_in};

    if (state_q == IDLE || state_d == IDLE || at_last) edge_cnt_d = '0;
    else                                              edge_cnt_d = edge_cnt_q + E_ONE;

    bit_cnt_d = bit_cnt_q;
    if (state_q != DATA)                     bit_cnt_d = '0;
    else if (at_last && bit_cnt_q != B_LAST) bit_cnt_d = bit_cnt_q + B_ONE;

    armed_d = armed_q;
    if (state_q == IDLE && rx_s) armed_d = 1'b1;
    if (state_q == CHECK)        armed_d = 1'b0;

    sample_d = sample_q;
    if (state_q != IDLE && edge_cnt_q == E_LOAD) sample_d = bit_value;

    seq_err_d = (state_q == DATA) && at_last && (bit_cnt_q == B_LAST) && !SIPO_DONE;
  end

  always_comb begin
    SIPO_EN       = (state_q == DATA)   && at_strobe;
    PAR_CHECK_EN  = (state_q == PARITY) && at_strobe;
    STOP_CHECK_EN = (state_q == STOP)   && at_strobe;
    RX_CHECK_EN   = (state_q == CHECK);
    start_glitch  = (state_q == START)  && at_strobe && sample_q;
    busy          = (state_q != IDLE);
  end

  assign sample_out_reg = sample_q;
  assign seq_err        = seq_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: stimulus queues expected strobes, a negedge monitor pops and compares.
module tb_uart_rx_ctrl;
  localparam int DW = 4;
  localparam int PS = 8;

  localparam logic [5:0] K_SIPO = 6'b000001;
  localparam logic [5:0] K_PAR  = 6'b000010;
  localparam logic [5:0] K_STOP = 6'b000100;
  localparam logic [5:0] K_CHK  = 6'b001000;
  localparam logic [5:0] K_GLT  = 6'b010000;
  localparam logic [5:0] K_SEQ  = 6'b100000;

  typedef struct packed {
    logic [5:0] kind;
    logic       smp;
  } ev_t;

  logic clk = 1'b0;
  logic rst;
  logic rx_in;
  logic sipo_done;
  logic sample_out_reg, sipo_en, par_check_en, stop_check_en, rx_check_en;
  logic busy, start_glitch, seq_err;

  ev_t  exp_q[$];
  ev_t  mon_ev;
  logic [5:0] mon_mask;
  int   checks = 0;
  int   failures = 0;
  int   force_done_low = 0;
  int   dp_cnt = 0;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE(PS), .PAR_EN(1)) dut (
    .clk(clk), .rst(rst), .rx_in(rx_in), .SIPO_DONE(sipo_done),
    .sample_out_reg(sample_out_reg), .SIPO_EN(sipo_en), .PAR_CHECK_EN(par_check_en),
    .STOP_CHECK_EN(stop_check_en), .RX_CHECK_EN(rx_check_en), .busy(busy),
    .start_glitch(start_glitch), .seq_err(seq_err)
  );

  // Monitor: every strobe/pulse cycle must match the head of the expectation queue.
  initial begin
    forever begin
      @(negedge clk);
      mon_mask = {seq_err, start_glitch, rx_check_en, stop_check_en, par_check_en, sipo_en};
      if (mon_mask != 6'b0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event kind=%b sample=%b required=none", mon_mask, sample_out_reg);
        end else begin
          mon_ev = exp_q.pop_front();
          if (mon_mask !== mon_ev.kind || sample_out_reg !== mon_ev.smp) begin
            failures++;
            $display("FAIL event kind=%b sample=%b required kind=%b sample=%b",
                     mon_mask, sample_out_reg, mon_ev.kind, mon_ev.smp);
          end
        end
      end
    end
  end

  // Minimal datapath stand-in: SIPO_DONE rises once DW bits have been shifted.
  initial begin
    sipo_done = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst)             dp_cnt = 0;
      else if (rx_check_en) dp_cnt = 0;
      else if (sipo_en)     dp_cnt++;
      sipo_done = (dp_cnt >= DW) && (force_done_low == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h required=%0h", name, got, exp);
    end
  endtask

  task automatic push(input logic [5:0] k, input logic s);
    ev_t e;
    e.kind = k;
    e.smp  = s;
    exp_q.push_back(e);
  endtask

  task automatic push_frame(input logic [3:0] d, input logic par, input logic stp, input logic se);
    for (int i = 0; i < DW; i++) push(K_SIPO, d[i]);
    if (se) push(K_SEQ, d[DW-1]);
    push(K_PAR, par);
    push(K_STOP, stp);
    push(K_CHK, stp);
  endtask

  task automatic hold(input logic v, input int n);
    rx_in = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input logic [3:0] d, input logic par, input logic stp);
    hold(1'b0, PS);
    for (int i = 0; i < DW; i++) hold(d[i], PS);
    hold(par, PS);
    hold(stp, PS);
  endtask

  initial begin
    int glitch_off;
    logic exp_b0;
    rst   = 1'b1;
    rx_in = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk("reset_outputs", {27'd0, sipo_en, par_check_en, stop_check_en, rx_check_en, busy}, 0);
    chk("reset_pulses", {30'd0, start_glitch, seq_err}, 0);
    chk("reset_sample", {31'd0, sample_out_reg}, 1);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    hold(1'b1, 10);
    chk("idle_busy", {31'd0, busy}, 0);

    // Frame 0x5, parity 1, stop 1.
    push_frame(4'h5, 1'b1, 1'b1, 1'b0);
    hold(1'b0, PS);
    chk("busy_in_frame", {31'd0, busy}, 1);
    for (int i = 0; i < DW; i++) hold(((4'h5 >> i) & 4'h1) != 4'h0, PS);
    hold(1'b1, PS);
    hold(1'b1, PS);
    hold(1'b1, 6);
    chk("busy_after_frame", {31'd0, busy}, 0);
    hold(1'b1, 10);

    // False start: 3 low cycles.
    push(K_GLT, 1'b1);
    hold(1'b0, 3);
    hold(1'b1, 20);
    chk("busy_after_glitch", {31'd0, busy}, 0);

    // Back-to-back 0xA then 0x3 with one bit of idle between.
    push_frame(4'hA, 1'b1, 1'b1, 1'b0);
    push_frame(4'h3, 1'b1, 1'b1, 1'b0);
    drive_frame(4'hA, 1'b1, 1'b1);
    hold(1'b1, PS);
    drive_frame(4'h3, 1'b1, 1'b1);
    hold(1'b1, 10);

    // Reset during data bit 2 of 0xC (bits 0,0,1,1).
    push(K_SIPO, 1'b0);
    push(K_SIPO, 1'b0);
    hold(1'b0, PS);
    hold(1'b0, PS);
    hold(1'b0, PS);
    hold(1'b1, 3);
    #1 rst = 1'b0;
    #1;
    chk("abort_outputs", {27'd0, sipo_en, par_check_en, stop_check_en, rx_check_en, busy}, 0);
    chk("abort_pulses", {30'd0, start_glitch, seq_err}, 0);
    chk("abort_sample", {31'd0, sample_out_reg}, 1);
    chk("abort_queue", exp_q.size(), 0);
    hold(1'b1, 3);
    rst = 1'b1;
    hold(1'b1, 10);
    push_frame(4'h6, 1'b1, 1'b1, 1'b0);
    drive_frame(4'h6, 1'b1, 1'b1);
    hold(1'b1, 10);

    // SIPO_DONE held low: seq_err in the cycle after the last data bit ends.
    force_done_low = 1;
    push_frame(4'h9, 1'b1, 1'b1, 1'b1);
    drive_frame(4'h9, 1'b1, 1'b1);
    hold(1'b1, 10);
    force_done_low = 0;

    // Stop bit 0 then line held low: one check, no restart until line idles.
    push_frame(4'h7, 1'b0, 1'b0, 1'b0);
    drive_frame(4'h7, 1'b0, 1'b0);
    hold(1'b0, 40);
    chk("busy_line_low", {31'd0, busy}, 0);
    hold(1'b1, 10);
    push_frame(4'h5, 1'b1, 1'b1, 1'b0);
    drive_frame(4'h5, 1'b1, 1'b1);
    hold(1'b1, 10);

    // One-cycle 0 glitch inside data bit 0 (value 1) of frame 0x1.
`ifdef RX_MAJ_VOTE_EN
    glitch_off = 5;
    exp_b0 = 1'b1;
`else
    glitch_off = 6;
    exp_b0 = 1'b0;
`endif
    push(K_SIPO, exp_b0);
    push(K_SIPO, 1'b0);
    push(K_SIPO, 1'b0);
    push(K_SIPO, 1'b0);
    push(K_PAR, 1'b0);
    push(K_STOP, 1'b1);
    push(K_CHK, 1'b1);
    hold(1'b0, PS);
    hold(1'b1, glitch_off);
    hold(1'b0, 1);
    hold(1'b1, PS - 1 - glitch_off);
    for (int i = 1; i < DW; i++) hold(1'b0, PS);
    hold(1'b0, PS);
    hold(1'b1, PS);
    hold(1'b1, 20);

    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
